// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with register 0 hardwired to zero and a post-reset clearing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                ready_o
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_e          state;
  logic [AW-1:0]   sweep_cnt;
  logic [XLEN-1:0] mem [NREG];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state     <= ST_INIT;
      sweep_cnt <= AW'(1);
      ready_o   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_cnt == LAST_REG) begin
            state   <= ST_RUN;
            ready_o <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
          end
        end
        ST_RUN: begin
          ready_o <= 1'b1;
        end
        default: begin
          state   <= ST_INIT;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the array has no reset; the INIT sweep clears it, which keeps it mappable onto RAM/flop arrays without reset.
  always_ff @(posedge clk_sys_i) begin
    if (state == ST_INIT) begin
      mem[sweep_cnt] <= '0;
    end else begin
      // Ascending port order: the last NBA wins, so port 1 overrides port 0 on a same-address conflict.
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
          mem[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata;

    assign ra = rd_addr_i[k*AW +: AW];

    // NOTE: rdata gets a value before any conditional update, so no latch can be inferred.
    always_comb begin
      rdata = mem[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == ra)) begin
          rdata = wr_data_i[w*XLEN +: XLEN];
        end
      end
`endif
      if ((state != ST_RUN) || (ra == '0)) begin
        rdata = '0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = rdata;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 2R/2W 32x32 instance and a 4R/1W 16x64 instance sharing clock and reset.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_sys_i = 1'b0;
  logic rst_sys_i;

  always #5 clk_sys_i = ~clk_sys_i;

  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a;
  logic [1:0]   wr_en_a;
  logic [9:0]   wr_addr_a;
  logic [63:0]  wr_data_a;
  logic         ready_a;

  logic [15:0]  rd_addr_b;
  logic [255:0] rd_data_b;
  logic [0:0]   wr_en_b;
  logic [3:0]   wr_addr_b;
  logic [63:0]  wr_data_b;
  logic         ready_b;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2)) dut_a (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .rd_addr_i (rd_addr_a),
    .rd_data_o (rd_data_a),
    .wr_en_i   (wr_en_a),
    .wr_addr_i (wr_addr_a),
    .wr_data_i (wr_data_a),
    .ready_o   (ready_a)
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(4), .NWR(1)) dut_b (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .rd_addr_i (rd_addr_b),
    .rd_data_o (rd_data_b),
    .wr_en_i   (wr_en_b),
    .wr_addr_i (wr_addr_b),
    .wr_data_i (wr_data_b),
    .ready_o   (ready_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys_i);
    #1;
  endtask

  function automatic logic [63:0] val_b(input int i);
    logic [7:0] tag;
    tag = i[7:0];
    return {tag, 56'hA5A5_5A5A_C3C3_3C};
  endfunction

  initial begin
    rst_sys_i = 1'b1;
    rd_addr_a = '0;
    wr_en_a   = '0;
    wr_addr_a = '0;
    wr_data_a = '0;
    rd_addr_b = '0;
    wr_en_b   = '0;
    wr_addr_b = '0;
    wr_data_b = '0;

    // Reset state.
    repeat (3) step();
    check("rst_ready_a", 64'(ready_a), 64'd0);
    check("rst_ready_b", 64'(ready_b), 64'd0);
    rd_addr_a = {5'd3, 5'd0};
    #1;
    check("rst_rd_a1", rd_data_a[63:32], 64'd0);

    // Release and sweep; write pulses during INIT must be ignored.
    rst_sys_i = 1'b0;
    wr_en_a   = 2'b11;
    wr_addr_a = {5'd6, 5'd5};
    wr_data_a = {32'hBAD0_0006, 32'hBAD0_0005};
    rd_addr_a = {5'd6, 5'd5};
    for (int e = 1; e <= 31; e++) begin
      step();
      check($sformatf("sweep_ready_a_e%0d", e), 64'(ready_a), 64'(e == 31));
      check($sformatf("sweep_ready_b_e%0d", e), 64'(ready_b), 64'(e >= 15));
      if (e == 10) begin
        check("init_rd_a0", rd_data_a[31:0], 64'd0);
        check("init_rd_a1", rd_data_a[63:32], 64'd0);
      end
      if (e == 30) wr_en_a = '0;
    end

    // Every register cleared by the sweep.
    for (int r = 0; r < 32; r += 2) begin
      rd_addr_a = {5'(r + 1), 5'(r)};
      #1;
      check($sformatf("clear_r%0d", r), rd_data_a[31:0], 64'd0);
      check($sformatf("clear_r%0d", r + 1), rd_data_a[63:32], 64'd0);
    end

    // Plain write, visible on both ports the next cycle.
    wr_en_a   = 2'b01;
    wr_addr_a = {5'd0, 5'd5};
    wr_data_a = {32'h0, 32'hDEADBEEF};
    rd_addr_a = {5'd1, 5'd2};
    step();
    wr_en_a   = '0;
    rd_addr_a = {5'd5, 5'd5};
    #1;
    check("wr5_p0", rd_data_a[31:0], 64'hDEADBEEF);
    check("wr5_p1", rd_data_a[63:32], 64'hDEADBEEF);

    // Writes to register 0 are discarded, bypass included.
    wr_en_a   = 2'b10;
    wr_addr_a = {5'd0, 5'd0};
    wr_data_a = {32'h12345678, 32'h0};
    rd_addr_a = {5'd0, 5'd0};
    #1;
    check("r0_same_cycle", rd_data_a[63:32], 64'd0);
    step();
    wr_en_a = '0;
    #1;
    check("r0_p0", rd_data_a[31:0], 64'd0);
    check("r0_p1", rd_data_a[63:32], 64'd0);

    // Same-address conflict: port 1 wins.
    wr_en_a   = 2'b11;
    wr_addr_a = {5'd7, 5'd7};
    wr_data_a = {32'h22222222, 32'h11111111};
    step();
    wr_en_a   = '0;
    rd_addr_a = {5'd7, 5'd7};
    #1;
    check("conflict_r7_p0", rd_data_a[31:0], 64'h22222222);
    check("conflict_r7_p1", rd_data_a[63:32], 64'h22222222);

    // Same-cycle read of a register being written.
    wr_en_a   = 2'b01;
    wr_addr_a = {5'd0, 5'd9};
    wr_data_a = {32'h0, 32'hCAFEF00D};
    rd_addr_a = {5'd9, 5'd9};
    #1;
    check("same_cycle_r9_p0", rd_data_a[31:0], BYP ? 64'hCAFEF00D : 64'd0);
    check("same_cycle_r9_p1", rd_data_a[63:32], BYP ? 64'hCAFEF00D : 64'd0);
    step();
    wr_en_a = '0;
    #1;
    check("next_cycle_r9_p0", rd_data_a[31:0], 64'hCAFEF00D);
    check("next_cycle_r9_p1", rd_data_a[63:32], 64'hCAFEF00D);

    // Same-cycle read while both ports write the same register.
    wr_en_a   = 2'b11;
    wr_addr_a = {5'd10, 5'd10};
    wr_data_a = {32'hBBBB0010, 32'hAAAA0010};
    rd_addr_a = {5'd7, 5'd10};
    #1;
    check("dual_byp_r10", rd_data_a[31:0], BYP ? 64'hBBBB0010 : 64'd0);
    check("dual_byp_r7", rd_data_a[63:32], 64'h22222222);
    step();
    wr_en_a = '0;
    #1;
    check("dual_next_r10", rd_data_a[31:0], 64'hBBBB0010);

    // Reset during RUN drops ready immediately and blanks reads.
    rst_sys_i = 1'b1;
    rd_addr_a = {5'd7, 5'd5};
    #1;
    check("run_rst_ready_a", 64'(ready_a), 64'd0);
    check("run_rst_ready_b", 64'(ready_b), 64'd0);
    check("run_rst_rd_p0", rd_data_a[31:0], 64'd0);
    check("run_rst_rd_p1", rd_data_a[63:32], 64'd0);
    step();
    rst_sys_i = 1'b0;
    repeat (9) step();

    // Sweep counter is now 10: reset again mid-sweep.
    rst_sys_i = 1'b1;
    #1;
    check("mid_rst_ready_a", 64'(ready_a), 64'd0);
    step();
    rst_sys_i = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e >= 30) check($sformatf("resweep_ready_a_e%0d", e), 64'(ready_a), 64'(e == 31));
      if (e == 14 || e == 15) check($sformatf("resweep_ready_b_e%0d", e), 64'(ready_b), 64'(e == 15));
    end
    #1;
    check("resweep_r5", rd_data_a[31:0], 64'd0);
    check("resweep_r7", rd_data_a[63:32], 64'd0);
    rd_addr_a = {5'd10, 5'd9};
    #1;
    check("resweep_r9", rd_data_a[31:0], 64'd0);
    check("resweep_r10", rd_data_a[63:32], 64'd0);

    // 16x64 instance with four read ports.
    for (int i = 1; i <= 15; i++) begin
      wr_en_b   = 1'b1;
      wr_addr_b = 4'(i);
      wr_data_b = val_b(i);
      step();
    end
    wr_en_b = '0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) rd_addr_b[k*4 +: 4] = 4'(4 * g + k + 1);
      #1;
      for (int k = 0; k < 4; k++) begin
        int a;
        a = (4 * g + k + 1) % 16;
        check($sformatf("b_rd_g%0d_k%0d", g, k), rd_data_b[k*64 +: 64], (a == 0) ? 64'd0 : val_b(a));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
